data_mem_responder: RTL and testbench

Responder end of the CPU data-memory interface. It accepts load/store requests from the core over a valid/ready request channel. It models a configurable wait-state memory, then returns load data or a store acknowledgement on a valid/ready response channel. It replaces the zero-latency data memory whenever the core runs with a stalling memory port.

---
 rtl/riscv_mem_pkg.sv | 25 ++
 rtl/mem_lane_align.sv | 45 ++++
 rtl/data_mem_responder.sv | 137 +++++++++++++
 tb/tb_data_mem_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the data-memory port: access sizes, responder states
// and error causes (the cause names are also used in bench messages).
package riscv_mem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef enum logic [1:0] {ERR_NONE, ERR_SIZE, ERR_MISALIGN, ERR_RANGE} err_cause_e;

  // Bits above the word index must all be zero; addresses never wrap.
  function automatic err_cause_e access_err(input logic [1:0] size,
                                            input logic [31:0] addr,
                                            input int idx_w);
    if (size == SIZE_X) return ERR_SIZE;
    if (size == SIZE_H && addr[0]) return ERR_MISALIGN;
    if (size == SIZE_W && addr[1:0] != 2'b00) return ERR_MISALIGN;
    if ((addr >> (idx_w + 2)) != 32'd0) return ERR_RANGE;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: store data replication + byte enables, and
// load lane extraction with zero/sign extension.
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [31:0] st_data_o,
  output logic [3:0]  st_be_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  b_lane;
  logic [15:0] h_lane;

  always_comb begin
    st_data_o = '0;
    st_be_o   = '0;
    ld_data_o = '0;
    b_lane    = rword_i[8*addr_lo_i +: 8];
    h_lane    = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
    case (size_i)
      SIZE_B: begin
        st_data_o = {4{wdata_i[7:0]}};
        st_be_o   = 4'b0001 << addr_lo_i;
        ld_data_o = {{24{b_lane[7] & ~unsigned_i}}, b_lane};
      end
      SIZE_H: begin
        st_data_o = {2{wdata_i[15:0]}};
        st_be_o   = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        ld_data_o = {{16{h_lane[15] & ~unsigned_i}}, h_lane};
      end
      SIZE_W: begin
        st_data_o = wdata_i;
        st_be_o   = 4'b1111;
        ld_data_o = rword_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Wait-state data-memory responder for the core's stalling memory port.
//   state | meaning
//   IDLE  | req_ready=1, waiting for a request handshake
//   WAIT  | counting down wait states; access executes on the edge leaving
//   RESP  | rsp_valid=1, result held until rsp_ready
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, uns_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic        accept, exec, rsp_done;
  logic        a_we, a_uns, a_err;
  logic [31:0] a_addr, a_wdata;
  logic [1:0]  a_size;
  logic [IDX_W-1:0] a_idx;
  logic [31:0] st_data, ld_data;
  logic [3:0]  st_be;

  assign accept   = req_valid && req_ready;
  assign rsp_done = rsp_valid && rsp_ready;
  assign exec     = (WAIT_CYCLES == 0) ? accept : (state_q == WAIT && cnt_q == 4'd0);

  // Zero-wait builds execute on the accept edge, straight from the request inputs.
  assign a_we    = (WAIT_CYCLES == 0) ? req_we       : we_q;
  assign a_addr  = (WAIT_CYCLES == 0) ? req_addr     : addr_q;
  assign a_wdata = (WAIT_CYCLES == 0) ? req_wdata    : wdata_q;
  assign a_size  = (WAIT_CYCLES == 0) ? req_size     : size_q;
  assign a_uns   = (WAIT_CYCLES == 0) ? req_unsigned : uns_q;
  assign a_err   = access_err(a_size, a_addr, IDX_W) != ERR_NONE;
  assign a_idx   = a_addr[IDX_W+1:2];

  mem_lane_align u_align (
    .size_i     (a_size),
    .addr_lo_i  (a_addr[1:0]),
    .unsigned_i (a_uns),
    .wdata_i    (a_wdata),
    .rword_i    (mem_q[a_idx]),
    .st_data_o  (st_data),
    .st_be_o    (st_be),
    .ld_data_o  (ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
        cnt_d   = CNT_INIT;
      end
      WAIT: if (cnt_q == 4'd0) state_d = RESP;
            else cnt_d = cnt_q - 4'd1;
      RESP: if (rsp_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = rst_n && (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
      end
      if (exec) begin
        err_q   <= a_err;
        rdata_q <= (a_err || a_we) ? '0 : ld_data;
      end else if (rsp_done) begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  // Array is deliberately not reset; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (exec && a_we && !a_err) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem_q[a_idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_CYCLES=2 instance for most
// scenarios and a WAIT_CYCLES=0 instance for the zero-wait throughput case.
module tb_data_mem_responder;
  import riscv_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = SIZE_W;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_req_valid = 1'b0, z_req_we = 1'b0, z_req_unsigned = 1'b0, z_rsp_ready = 1'b1;
  logic [31:0] z_req_addr = '0, z_req_wdata = '0;
  logic [1:0]  z_req_size = SIZE_W;
  logic        z_req_ready, z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_size(z_req_size),
    .req_unsigned(z_req_unsigned),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  // Issue one request and return once rsp_valid is seen (left in RESP).
  // lat = edges after the accept edge until rsp_valid is visible.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, input logic uns, output int lat);
    int n;
    n = 0;
    req_we = we; req_addr = addr; req_wdata = wd; req_size = sz; req_unsigned = uns;
    req_valid = 1'b1;
    while (!req_ready && n < 40) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_timeout: rsp_valid=0 after %0d edges, required 1", lat);
    end
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [1:0] sz, input logic uns,
                     output logic [31:0] rd, output logic er, output int lat);
    issue(we, addr, wd, sz, uns, lat);
    rd = rsp_rdata;
    er = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b exp 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h exp 0", rsp_rdata); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err: got %b exp 0", rsp_err); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_held_ready: got %b exp 0", req_ready); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready: got %b exp 1", req_ready); end
    checks++; if (z_req_ready !== 1'b1) begin errors++; $display("FAIL idle_z_req_ready: got %b exp 1", z_req_ready); end
  endtask

  task automatic test_word_store_load;
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 32'h10, 32'hDEADBEEF, SIZE_W, 1'b0, rd, er, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d exp 2", lat); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL sw_err: got %b exp 0", er); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sw_rdata: got %h exp 0", rd); end
    txn(1'b0, 32'h10, 32'h0, SIZE_W, 1'b0, rd, er, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d exp 2", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h exp deadbeef", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL lw_err: got %b exp 0", er); end
  endtask

  task automatic test_byte_merge;
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 32'h20, 32'h11223344, SIZE_W, 1'b0, rd, er, lat);
    txn(1'b1, 32'h21, 32'h12345680, SIZE_B, 1'b0, rd, er, lat);
    checks++; if (er !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL sb_rsp: got err=%b rdata=%h exp err=0 rdata=0", er, rd); end
    txn(1'b0, 32'h20, 32'h0, SIZE_W, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'h11228044) begin errors++; $display("FAIL sb_merge: got %h exp 11228044", rd); end
    txn(1'b0, 32'h21, 32'h0, SIZE_B, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed: got %h exp ffffff80", rd); end
    txn(1'b0, 32'h21, 32'h0, SIZE_B, 1'b1, rd, er, lat);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu: got %h exp 00000080", rd); end
    txn(1'b0, 32'h22, 32'h0, SIZE_H, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'h00001122) begin errors++; $display("FAIL lh_hi: got %h exp 00001122", rd); end
    txn(1'b0, 32'h20, 32'h0, SIZE_H, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'hFFFF8044) begin errors++; $display("FAIL lh_signed: got %h exp ffff8044", rd); end
    txn(1'b0, 32'h20, 32'h0, SIZE_H, 1'b1, rd, er, lat);
    checks++; if (rd !== 32'h00008044) begin errors++; $display("FAIL lhu: got %h exp 00008044", rd); end
    txn(1'b1, 32'h24, 32'h0, SIZE_W, 1'b0, rd, er, lat);
    txn(1'b1, 32'h26, 32'hAAAABEEF, SIZE_H, 1'b0, rd, er, lat);
    txn(1'b0, 32'h24, 32'h0, SIZE_W, 1'b1, rd, er, lat);
    checks++; if (rd !== 32'hBEEF0000) begin errors++; $display("FAIL sh_upper_lanes: got %h exp beef0000", rd); end
  endtask

  task automatic test_errors;
    logic [31:0] rd; logic er; int lat;
    txn(1'b0, 32'h22, 32'h0, SIZE_W, 1'b0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lw_misaligned: got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
    txn(1'b1, 32'h30, 32'h55667788, SIZE_W, 1'b0, rd, er, lat);
    txn(1'b1, 32'h31, 32'h0000FFFF, SIZE_H, 1'b0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL sh_misaligned: got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
    txn(1'b0, 32'h30, 32'h0, SIZE_W, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'h55667788 || er !== 1'b0) begin errors++; $display("FAIL sh_misaligned_nowrite: got %h err=%b exp 55667788 err=0", rd, er); end
    txn(1'b0, 32'h400, 32'h0, SIZE_W, 1'b0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL lw_range: got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
    txn(1'b0, 32'h80000000, 32'h0, SIZE_B, 1'b0, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL lb_range_high: got err=%b exp 1", er); end
    txn(1'b1, 32'h0, 32'h0, SIZE_W, 1'b0, rd, er, lat);
    txn(1'b1, 32'h400, 32'h99999999, SIZE_W, 1'b0, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL sw_range: got err=%b exp 1", er); end
    txn(1'b0, 32'h0, 32'h0, SIZE_W, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sw_range_nowrap: got %h exp 0", rd); end
    txn(1'b0, 32'h30, 32'h0, SIZE_X, 1'b0, rd, er, lat);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL size_illegal: got err=%b rdata=%h exp err=1 rdata=0", er, rd); end
    txn(1'b1, 32'h3FC, 32'h0BADC0DE, SIZE_W, 1'b0, rd, er, lat);
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL sw_last_word: got err=%b exp 0", er); end
    txn(1'b0, 32'h3FC, 32'h0, SIZE_W, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'h0BADC0DE) begin errors++; $display("FAIL lw_last_word: got %h exp 0badc0de", rd); end
  endtask

  task automatic test_backpressure;
    int lat;
    issue(1'b0, 32'h10, 32'h0, SIZE_W, 1'b0, lat);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20; req_size = SIZE_W;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0)
        begin errors++; $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h ready=%b exp 1 deadbeef 0", i, rsp_valid, rsp_rdata, req_ready); end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b exp 0 1", rsp_valid, req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept: got ready=%b exp 0", req_ready); end
    lat = 0;
    while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 2 || rsp_rdata !== 32'h11228044) begin errors++; $display("FAIL bp_second: got lat=%0d rdata=%h exp 2 11228044", lat, rsp_rdata); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op;
    logic [31:0] rd; logic er; int lat;
    txn(1'b1, 32'h40, 32'h0, SIZE_W, 1'b0, rd, er, lat);
    req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFEF00D; req_size = SIZE_W; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2; rst_n = 1'b0; #1;
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0)
      begin errors++; $display("FAIL rst_wait_outputs: got ready=%b valid=%b rdata=%h err=%b exp all 0", req_ready, rsp_valid, rsp_rdata, rsp_err); end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_wait_idle: got ready=%b exp 1", req_ready); end
    txn(1'b0, 32'h40, 32'h0, SIZE_W, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rst_wait_nocommit: got %h exp 0", rd); end

    issue(1'b0, 32'h10, 32'h0, SIZE_W, 1'b0, lat);
    #2; rst_n = 1'b0; #1;
    checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_data: got valid=%b rdata=%h exp 0 0", rsp_valid, rsp_rdata); end
    @(posedge clk); #1; rst_n = 1'b1; @(posedge clk); #1;

    issue(1'b0, 32'h402, 32'h0, SIZE_W, 1'b0, lat);
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL rst_resp_err_pre: got err=%b exp 1", rsp_err); end
    #2; rst_n = 1'b0; #1;
    checks++; if (rsp_err !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_err: got err=%b valid=%b exp 0 0", rsp_err, rsp_valid); end
    @(posedge clk); #1; rst_n = 1'b1; @(posedge clk); #1;

    issue(1'b1, 32'h44, 32'h12345678, SIZE_W, 1'b0, lat);
    #2; rst_n = 1'b0; #1;
    @(posedge clk); #1; rst_n = 1'b1; @(posedge clk); #1;
    txn(1'b0, 32'h44, 32'h0, SIZE_W, 1'b0, rd, er, lat);
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL rst_resp_committed: got %h exp 12345678", rd); end
  endtask

  task automatic test_zero_wait;
    z_rsp_ready = 1'b1;
    z_req_we = 1'b1; z_req_addr = 32'h8; z_req_wdata = 32'hA5A5A5A5; z_req_size = SIZE_W; z_req_unsigned = 1'b0;
    z_req_valid = 1'b1;
    @(posedge clk); #1;
    checks++; if (z_rsp_valid !== 1'b1 || z_rsp_err !== 1'b0 || z_req_ready !== 1'b0) begin errors++; $display("FAIL z_store_rsp: got valid=%b err=%b ready=%b exp 1 0 0", z_rsp_valid, z_rsp_err, z_req_ready); end
    z_req_we = 1'b0; z_req_addr = 32'h9; z_req_size = SIZE_B; z_req_unsigned = 1'b1;
    @(posedge clk); #1;
    checks++; if (z_rsp_valid !== 1'b0 || z_req_ready !== 1'b1) begin errors++; $display("FAIL z_handshake: got valid=%b ready=%b exp 0 1", z_rsp_valid, z_req_ready); end
    @(posedge clk); #1;
    checks++; if (z_rsp_valid !== 1'b1 || z_rsp_rdata !== 32'h000000A5) begin errors++; $display("FAIL z_lbu: got valid=%b rdata=%h exp 1 000000a5", z_rsp_valid, z_rsp_rdata); end
    z_req_addr = 32'hA; z_req_size = SIZE_H; z_req_unsigned = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (z_rsp_valid !== 1'b1 || z_rsp_rdata !== 32'hFFFFA5A5) begin errors++; $display("FAIL z_lh: got valid=%b rdata=%h exp 1 ffffa5a5", z_rsp_valid, z_rsp_rdata); end
    z_req_addr = 32'h400; z_req_size = SIZE_W;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (z_rsp_err !== 1'b1 || z_rsp_rdata !== 32'h0) begin errors++; $display("FAIL z_range: got err=%b rdata=%h exp 1 0", z_rsp_err, z_rsp_rdata); end
    z_req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (z_rsp_valid !== 1'b0 || z_rsp_err !== 1'b0) begin errors++; $display("FAIL z_done: got valid=%b err=%b exp 0 0", z_rsp_valid, z_rsp_err); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by 200000 time units");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_word_store_load();
    test_byte_merge();
    test_errors();
    test_backpressure();
    test_reset_mid_op();
    test_zero_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
